// File: rtl/vec_mag_pkg.sv
// vec_mag_pkg: shared FSM states, packed-word field slots and default coordinate width
package vec_mag_pkg;
   localparam int COORD_WIDTH_DEF = 8;
   typedef enum logic [1:0] {S_X1, S_Y1, S_X2, S_Y2} state_e;
   // field slot index inside m_axis_tdata, in units of COORD_WIDTH (x1 in the MSBs)
   localparam int X1_F = 3;
   localparam int Y1_F = 2;
   localparam int X2_F = 1;
   localparam int Y2_F = 0;
endpackage

// File: rtl/vec_axis_out_slot.sv
// vec_axis_out_slot: single-entry output register with valid/ready; holds its word until taken
module vec_axis_out_slot #(
   parameter int W = 32
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o
);
   logic         valid_q, valid_d, last_q, last_d;
   logic [W-1:0] data_q, data_d;
   // the producer only loads when the slot is empty or draining, so no overwrite of a held word
   always_comb begin
      valid_d = !clr_i && (load_i || (valid_q && !ready_i));
      data_d  = clr_i ? '0 : load_i ? data_i : data_q;
      last_d  = clr_i ? 1'b0 : load_i ? last_i : last_q;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = valid_q && last_q;
endmodule

// File: rtl/vec_coord_packer.sv
// vec_coord_packer: packs signed coordinate beats into {x1,y1,x2,y2} AXI-Stream words.
// Define VEC_PACK_RADIUS_EN to add radius_mode_i (two-beat groups, x1 = y1 = 0).
module vec_coord_packer
   import vec_mag_pkg::*;
#(
   parameter int COORD_WIDTH = COORD_WIDTH_DEF,
   parameter int BURST_LEN   = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [COORD_WIDTH-1:0]   s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [4*COORD_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   input  logic                     pack_clear_i,
`ifdef VEC_PACK_RADIUS_EN
   input  logic                     radius_mode_i,
`endif
   output logic                     packer_busy_o,
   output logic [31:0]              packet_cnt_o,
   output logic                     frame_err_o
);
   localparam int DW = 4 * COORD_WIDTH;
   localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   state_e                 state_q, state_d;
   logic [COORD_WIDTH-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d;
   logic [BW-1:0]          burst_q, burst_d;
   logic [31:0]            pkt_q, pkt_d;
   logic                   err_q, err_d, rdy_en_q, rdy_en_d;
   logic                   radius, s_hs, m_hs, lead, grp_done, frame_err, burst_end;
   logic [DW-1:0]          word;
`ifdef VEC_PACK_RADIUS_EN
   assign radius = radius_mode_i;
`else
   assign radius = 1'b0;
`endif
   assign s_hs      = s_axis_tvalid && s_axis_tready;
   assign m_hs      = m_axis_tvalid && m_axis_tready && !pack_clear_i;
   assign lead      = s_hs && state_q == S_X1;
   assign grp_done  = s_hs && state_q == S_Y2;
   assign frame_err = s_hs && s_axis_tlast && state_q != S_Y2;
   assign burst_end = burst_q == BW'(BURST_LEN - 1);
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= S_X1;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (pack_clear_i || frame_err) state_d = S_X1;
      else if (s_hs)
         case (state_q)
            S_X1:    state_d = radius ? S_Y2 : S_Y1;
            S_Y1:    state_d = S_X2;
            S_X2:    state_d = S_Y2;
            default: state_d = S_X1;
         endcase
   end
   // tready stays low until the first edge after reset release and during a flush
   always_comb begin
      s_axis_tready = rdy_en_q && !pack_clear_i && (state_q != S_Y2 || !m_axis_tvalid || m_axis_tready);
      packer_busy_o = state_q != S_X1 || m_axis_tvalid;
   end
   always_comb begin
      rdy_en_d = 1'b1;
      x1_d     = lead ? (radius ? '0 : s_axis_tdata) : x1_q;
      y1_d     = (s_hs && state_q == S_Y1) ? s_axis_tdata : (lead && radius) ? '0 : y1_q;
      x2_d     = (s_hs && state_q == S_X2) || (lead && radius) ? s_axis_tdata : x2_q;
      burst_d  = pack_clear_i ? '0 : grp_done ? ((s_axis_tlast || burst_end) ? '0 : burst_q + 1'b1) : burst_q;
      pkt_d    = pack_clear_i ? '0 : m_hs ? pkt_q + 32'd1 : pkt_q;
      err_d    = !pack_clear_i && (err_q || frame_err);
      word     = '0;
      word[X1_F*COORD_WIDTH +: COORD_WIDTH] = x1_q;
      word[Y1_F*COORD_WIDTH +: COORD_WIDTH] = y1_q;
      word[X2_F*COORD_WIDTH +: COORD_WIDTH] = x2_q;
      word[Y2_F*COORD_WIDTH +: COORD_WIDTH] = s_axis_tdata;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x1_q     <= '0;
         y1_q     <= '0;
         x2_q     <= '0;
         burst_q  <= '0;
         pkt_q    <= '0;
         err_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         x2_q     <= x2_d;
         burst_q  <= burst_d;
         pkt_q    <= pkt_d;
         err_q    <= err_d;
         rdy_en_q <= rdy_en_d;
      end
   end
   vec_axis_out_slot #(.W(DW)) u_slot (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr_i   (pack_clear_i),
      .load_i  (grp_done),
      .data_i  (word),
      .last_i  (s_axis_tlast || burst_end),
      .ready_i (m_axis_tready),
      .valid_o (m_axis_tvalid),
      .data_o  (m_axis_tdata),
      .last_o  (m_axis_tlast)
   );
   assign packet_cnt_o = pkt_q;
   assign frame_err_o  = err_q;
endmodule
